// File: rtl/m1_mealy_pkg.sv
`timescale 1ns/100ps
// -----------------------------------------------------------------------------
// m1_mealy_pkg
// Shared definitions for the "a b b a" Mealy recognizer:
//   - input symbol codes (a, b; every other code is a break symbol)
//   - 2-bit state encoding
//   - default propagation delays for the modelled timing paths
// -----------------------------------------------------------------------------
package m1_mealy_pkg;

    // Input symbols. Codes 2'b10 and 2'b11 are "other" and break any match.
    localparam logic [1:0] SYM_A = 2'b00;
    localparam logic [1:0] SYM_B = 2'b01;

    // Each state names the longest prefix of "abba" matched so far.
    typedef enum logic [1:0] {
        S0   = 2'd0,  // nothing matched
        SA   = 2'd1,  // "a"
        SAB  = 2'd2,  // "ab"
        SABB = 2'd3   // "abb"
    } state_t;

    // Default delays, in time units.
    localparam int D_SIGMA_DEF = 2;  // next-state network
    localparam int D_REG_DEF   = 1;  // state register clock-to-Q
    localparam int D_OMEGA_DEF = 2;  // output network

endpackage

// File: rtl/m1_state_reg.sv
`timescale 1ns/100ps
// -----------------------------------------------------------------------------
// m1_state_reg
// 2-bit positive-edge state register with asynchronous active-low clear and a
// modelled clock-to-Q delay.
//   clock   : rising-edge clock
//   reset_n : asynchronous active-low clear (forces S0 immediately)
//   d       : next state
//   q       : current state, valid D_REG after each rising edge
// -----------------------------------------------------------------------------
module m1_state_reg
    import m1_mealy_pkg::*;
#(
    parameter int D_REG = D_REG_DEF
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic [1:0] d,
    output logic [1:0] q
);

    logic [1:0] q_raw;
    logic [1:0] q_dly;

    // NOTE: state is written with non-blocking assignments so every flop samples
    // the pre-edge value of its inputs, independent of process ordering.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            q_raw <= S0;
        end else begin
            q_raw <= d;
        end
    end

    // Clock-to-Q delay applies to clocked updates only.
    assign #D_REG q_dly = q_raw;

    // NOTE: the clear bypasses the clock-to-Q model so the state reads S0 the
    // moment reset_n falls, not D_REG later.
    assign q = reset_n ? q_dly : S0;

endmodule

// File: rtl/m1_mealy.sv
`timescale 1ns/100ps
// -----------------------------------------------------------------------------
// m1_mealy
// Mealy recognizer for the symbol sequence a b b a (a = 00, b = 01) with
// overlap: the terminating a starts the next match. The next-state (sigma) and
// output (omega) networks carry modelled propagation delays so the minimum
// usable clock period can be demonstrated; synthesis ignores the delays.
//   z       : output, high while in "abb" and the current symbol is a
//   x       : input symbol, x[1] is the MSB
//   clock   : rising-edge clock
//   reset_n : asynchronous active-low reset, forces S0
// -----------------------------------------------------------------------------
module m1_mealy
    import m1_mealy_pkg::*;
#(
    parameter int D_SIGMA = D_SIGMA_DEF,
    parameter int D_REG   = D_REG_DEF,
    parameter int D_OMEGA = D_OMEGA_DEF
) (
    output logic       z,
    input  logic [1:2] x,
    input  logic       clock,
    input  logic       reset_n
);

    logic [1:0] state;
    logic [1:0] next_state;
    logic       is_a;
    logic       is_b;

    assign is_a = (x == SYM_A);
    assign is_b = (x == SYM_B);

    // Sigma, written per state bit:
    //   bit 1 set only for SA/SAB on b (-> SAB, SABB)
    //   bit 0 set on any a (-> SA) or SAB on b (-> SABB)
    // Every other case, including the break symbols, returns to S0.
    assign #D_SIGMA next_state = {
        is_b & (state[1] ^ state[0]),
        is_a | (is_b & state[1] & ~state[0])
    };

    // Omega: Mealy output, deliberately unregistered.
    assign #D_OMEGA z = is_a & (state == SABB);

    m1_state_reg #(
        .D_REG (D_REG)
    ) u_state_reg (
        .clock   (clock),
        .reset_n (reset_n),
        .d       (next_state),
        .q       (state)
    );

endmodule

// File: tb/tb_m1_mealy.sv
`timescale 1ns/100ps
// -----------------------------------------------------------------------------
// tb_m1_mealy
// Self-checking bench for m1_mealy: an absolute-time walk through one abba
// detection, then directed and random symbol streams checked through a
// scoreboard against a history-based reference model, a mid-match reset, and
// a run at clock period 2 where detection must not occur.
// -----------------------------------------------------------------------------
module tb_m1_mealy;
    import m1_mealy_pkg::*;

    logic       z;
    logic [1:2] x;
    logic       clock;
    logic       reset_n;

    int low_t  = 3;
    int high_t = 1;

    int n_tests = 0;
    int n_fail  = 0;

    bit         exp_q[$];   // expected z, one entry per issued symbol
    logic [1:0] hist[$];    // last (up to) three symbols accepted since reset

    m1_mealy dut (
        .z       (z),
        .x       (x),
        .clock   (clock),
        .reset_n (reset_n)
    );

    // Clock: low low_t, high high_t; defaults put rising edges at 3, 7, 11, ...
    initial begin
        clock = 1'b0;
        forever begin
            #(low_t) clock = 1'b1;
            #(high_t) clock = 1'b0;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at t=%0t: got %0h, expected %0h", name, $time, act, exp);
        end
    endtask

    // Reference: z is high exactly when the three symbols accepted since reset
    // immediately before the current one spell a b b and the current one is a.
    function automatic bit model_z(input logic [1:0] sym);
        if (hist.size() != 3) return 1'b0;
        return (hist[0] == SYM_A) && (hist[1] == SYM_B) &&
               (hist[2] == SYM_B) && (sym == SYM_A);
    endfunction

    // One symbol per cycle, applied at the falling edge. With rst set, reset
    // is held low across the next rising edge, so that symbol is discarded.
    task automatic issue(input logic [1:0] sym, input bit rst);
        @(negedge clock);
        reset_n = rst ? 1'b0 : 1'b1;
        x       = sym;
        if (rst) begin
            hist.delete();
            exp_q.push_back(1'b0);
        end else begin
            exp_q.push_back(model_z(sym));
            hist.push_back(sym);
            if (hist.size() > 3) void'(hist.pop_front());
        end
    endtask

    // Monitor: z is settled 0.5 before each rising edge (period 4).
    initial begin
        forever begin
            bit e;
            @(posedge clock);
            #3.5;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("scoreboard z", 32'(z), 32'(e));
            end
        end
    end

    // Watchdog
    initial begin
        #20000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [1:0] ovl[7];
        logic [1:0] brk1[5];
        logic [1:0] brk2[3];
        logic [1:0] slow[5];
        bit         saw_z;

        ovl  = '{SYM_A, SYM_B, SYM_B, SYM_A, SYM_B, SYM_B, SYM_A};
        brk1 = '{SYM_A, SYM_B, SYM_B, SYM_B, SYM_A};
        brk2 = '{SYM_A, SYM_B, 2'b11};
        slow = '{SYM_B, SYM_B, SYM_A, SYM_A, SYM_A};

        // ---- Reset and absolute-time abba detection -------------------------
        x       = 2'b01;
        reset_n = 1'b0;
        #0.5;
        check("reset state", 32'(dut.state), 32'(S0));
        x = SYM_A;
        #1.5 reset_n = 1'b1;                                   // t = 2
        #0.5 check("reset z", 32'(z), 32'd0);                  // t = 2.5
        #1.5 x = SYM_B;                                        // t = 4
        #0.5 check("state after edge 3", 32'(dut.state), 32'(SA));
        #4   check("state after edge 7", 32'(dut.state), 32'(SAB));
        #4   check("state after edge 11", 32'(dut.state), 32'(SABB));
        check("z in abb with b", 32'(z), 32'd0);               // t = 12.5
        #0.5 x = SYM_A;                                        // t = 13
        #1.5 check("z before D_OMEGA", 32'(z), 32'd0);         // t = 14.5
        #1   check("z rises", 32'(z), 32'd1);                  // t = 15.5
        #2   check("z still high", 32'(z), 32'd1);             // t = 17.5
        #1   check("z falls", 32'(z), 32'd0);                  // t = 18.5

        // ---- Scoreboard: directed sequences ---------------------------------
        issue(SYM_A, 1'b1);
        foreach (ovl[i]) issue(ovl[i], 1'b0);
        issue(SYM_A, 1'b1);
        foreach (brk1[i]) issue(brk1[i], 1'b0);
        issue(SYM_A, 1'b1);
        foreach (brk2[i]) issue(brk2[i], 1'b0);

        // ---- Scoreboard: random stream, a/b heavy, occasional reset ---------
        for (int n = 0; n < 300; n++) begin
            int         r;
            logic [1:0] sym;
            r = $urandom_range(0, 9);
            if (r < 4)       sym = SYM_A;
            else if (r < 8)  sym = SYM_B;
            else if (r == 8) sym = 2'b10;
            else             sym = 2'b11;
            issue(sym, $urandom_range(0, 15) == 0);
        end
        #4;
        check("scoreboard drained", 32'(exp_q.size()), 32'd0);

        // ---- Mid-match reset -------------------------------------------------
        @(negedge clock);
        reset_n = 1'b0;
        x       = SYM_A;
        @(negedge clock) reset_n = 1'b1;
        @(negedge clock) x = SYM_B;
        @(negedge clock) x = SYM_B;
        @(negedge clock) x = SYM_A;
        #2.5 check("mid-match z high", 32'(z), 32'd1);
        reset_n = 1'b0;
        #2.2 check("z drops on reset", 32'(z), 32'd0);
        @(negedge clock) reset_n = 1'b1;                       // edge in between ignored
        #2.5 check("reset discards match", 32'(z), 32'd0);

        // ---- Clock period 2: detection must not happen ----------------------
        @(negedge clock);
        reset_n = 1'b0;
        x       = SYM_A;
        @(posedge clock);
        low_t  = 1;
        high_t = 1;
        @(negedge clock) reset_n = 1'b1;
        saw_z = 1'b0;
        foreach (slow[i]) begin
            @(negedge clock) x = slow[i];
            repeat (3) begin
                #0.5;
                if (z === 1'b1) saw_z = 1'b1;
            end
        end
        check("period 2 no detection", 32'(saw_z), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
